// File: rtl/i2c_slave_responder.sv
// I2C slave responder: answers one 7-bit address, ACKs every written byte and
// returns bytes from tx_data_i on reads. All bus inputs are synchronised to the core clock.
module i2c_slave_responder #(
  parameter int unsigned          DATA_SIZE  = 8,
  parameter int unsigned          ADDR_SIZE  = 7,
  parameter logic [ADDR_SIZE-1:0] SLAVE_ADDR = 7'h50
) (
  input  logic                 i2c_core_clk_i,
  input  logic                 reset_i,
  input  logic                 i2c_scl_i,
  input  logic                 i2c_sda_i,
  output logic                 i2c_sda_o,
  input  logic [DATA_SIZE-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [DATA_SIZE-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 rw_o,
  output logic                 busy_o
);

  localparam logic [3:0] AddrBits = 4'(ADDR_SIZE + 1);
  localparam logic [3:0] DataBits = 4'(DATA_SIZE);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StRxByte, StRxAck, StTxByte, StTxAck, StWaitStop
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           scl_sync_q, scl_sync_d;
  logic [2:0]           sda_sync_q, sda_sync_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_SIZE:0]   addr_shift_q, addr_shift_d;
  logic [DATA_SIZE-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_SIZE-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_SIZE-1:0] rx_data_q, rx_data_d;
  logic                 sda_o_q, sda_o_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 rw_q, rw_d;

  logic scl_hi, scl_rise, scl_fall, sda_in, sda_rise, sda_fall;
  logic start_det, stop_det, load_tx;

  // [0],[1] form the synchroniser, [2] is the history flop used for edge detection
  assign scl_sync_d = {scl_sync_q[1:0], i2c_scl_i};
  assign sda_sync_d = {sda_sync_q[1:0], i2c_sda_i};

  assign scl_hi    = scl_sync_q[1];
  assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
  assign sda_in    = sda_sync_q[1];
  assign sda_rise  = sda_sync_q[1] & ~sda_sync_q[2];
  assign sda_fall  = ~sda_sync_q[1] & sda_sync_q[2];
  assign start_det = sda_fall & scl_hi;
  assign stop_det  = sda_rise & scl_hi;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_shift_d = addr_shift_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    rx_data_d    = rx_data_q;
    sda_o_d      = sda_o_q;
    rx_valid_d   = 1'b0;
    tx_ready_d   = 1'b0;
    rw_d         = rw_q;
    load_tx      = 1'b0;

    if (stop_det) begin
      state_d = StIdle;
      cnt_d   = '0;
      sda_o_d = 1'b1;
    end else if (start_det) begin
      state_d = StAddr;
      cnt_d   = '0;
      sda_o_d = 1'b1;
    end else begin
      unique case (state_q)
        StAddr: begin
          if (scl_rise && cnt_q < AddrBits) begin
            addr_shift_d = {addr_shift_q[ADDR_SIZE-1:0], sda_in};
            cnt_d        = cnt_q + 4'd1;
            if (cnt_q == AddrBits - 4'd1) begin
              if (addr_shift_d[ADDR_SIZE:1] == SLAVE_ADDR) begin
                rw_d = sda_in;
              end else begin
                state_d = StWaitStop;
                cnt_d   = '0;
              end
            end
          end else if (scl_fall && cnt_q == AddrBits) begin
            state_d = StAddrAck;
            cnt_d   = '0;
            sda_o_d = 1'b0;
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            if (rw_q) begin
              load_tx = 1'b1;
            end else begin
              state_d = StRxByte;
              cnt_d   = '0;
              sda_o_d = 1'b1;
            end
          end
        end
        StRxByte: begin
          if (scl_rise && cnt_q < DataBits) begin
            rx_shift_d = {rx_shift_q[DATA_SIZE-2:0], sda_in};
            cnt_d      = cnt_q + 4'd1;
            if (cnt_q == DataBits - 4'd1) begin
              rx_data_d  = rx_shift_d;
              rx_valid_d = 1'b1;
            end
          end else if (scl_fall && cnt_q == DataBits) begin
            state_d = StRxAck;
            cnt_d   = '0;
            sda_o_d = 1'b0;
          end
        end
        StRxAck: begin
          if (scl_fall) begin
            state_d = StRxByte;
            cnt_d   = '0;
            sda_o_d = 1'b1;
          end
        end
        StTxByte: begin
          if (scl_fall) begin
            if (cnt_q == DataBits - 4'd1) begin
              state_d = StTxAck;
              cnt_d   = '0;
              sda_o_d = 1'b1;
            end else begin
              tx_shift_d = tx_shift_q << 1;
              sda_o_d    = tx_shift_q[DATA_SIZE-2];
              cnt_d      = cnt_q + 4'd1;
            end
          end
        end
        StTxAck: begin
          // cnt_q==1 marks that the master ACKed and another byte is due
          if (scl_rise && cnt_q == 4'd0) begin
            if (sda_in) begin
              state_d = StWaitStop;
            end else begin
              cnt_d = 4'd1;
            end
          end else if (scl_fall && cnt_q == 4'd1) begin
            load_tx = 1'b1;
          end
        end
        default: ;
      endcase

      if (load_tx) begin
        state_d    = StTxByte;
        cnt_d      = '0;
        tx_shift_d = tx_valid_i ? tx_data_i : '1;
        tx_ready_d = tx_valid_i;
        sda_o_d    = tx_valid_i ? tx_data_i[DATA_SIZE-1] : 1'b1;
      end
    end
  end

  always_ff @(posedge i2c_core_clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      cnt_q        <= '0;
      addr_shift_q <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      rx_data_q    <= '0;
      sda_o_q      <= 1'b1;
      rx_valid_q   <= 1'b0;
      tx_ready_q   <= 1'b0;
      rw_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      cnt_q        <= cnt_d;
      addr_shift_q <= addr_shift_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      rx_data_q    <= rx_data_d;
      sda_o_q      <= sda_o_d;
      rx_valid_q   <= rx_valid_d;
      tx_ready_q   <= tx_ready_d;
      rw_q         <= rw_d;
    end
  end

  assign i2c_sda_o  = sda_o_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign tx_ready_o = tx_ready_q;
  assign rw_o       = rw_q;
  assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: a bit-banged I2C master drives a wired-AND bus against the responder.
module tb_i2c_slave_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_sda;
  logic       sda_o;
  logic       sda_line;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rw;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;
  int rx_pulses = 0;
  int tx_pulses = 0;

  assign sda_line = m_sda & sda_o;

  always #5 clk = ~clk;

  i2c_slave_responder dut (
    .i2c_core_clk_i(clk),
    .reset_i       (reset),
    .i2c_scl_i     (scl),
    .i2c_sda_i     (sda_line),
    .i2c_sda_o     (sda_o),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rw_o          (rw),
    .busy_o        (busy)
  );

  always @(posedge clk) begin
    if (rx_valid) rx_pulses <= rx_pulses + 1;
    if (tx_ready) tx_pulses <= tx_pulses + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; tick(8);
    scl   = 1'b1; tick(8);
    m_sda = 1'b0; tick(8);
    scl   = 1'b0; tick(8);
  endtask

  task automatic bus_stop();
    scl   = 1'b0;
    m_sda = 1'b0; tick(8);
    scl   = 1'b1; tick(8);
    m_sda = 1'b1; tick(8);
  endtask

  // One SCL clock; returns the bus level sampled mid-high
  task automatic clock_bit(input logic b, output logic seen);
    m_sda = b;    tick(4);
    scl   = 1'b1; tick(4);
    seen  = sda_line; tick(4);
    scl   = 1'b0; tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic x;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], x);
    clock_bit(1'b1, ack);
  endtask

  task automatic recv_bits(output logic [7:0] d);
    for (int i = 7; i >= 0; i--) clock_bit(1'b1, d[i]);
  endtask

  initial begin
    logic       ack;
    logic       x;
    logic [7:0] d;
    int         rx0;
    int         tx0;

    reset = 1'b1; scl = 1'b1; m_sda = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;
    tick(3);
    chk("reset_sda", sda_o, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_tx_ready", tx_ready, 0);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rw", rw, 0);
    reset = 1'b0;
    tick(4);

    // Write 0x50 + 0xA5
    bus_start();
    chk("wr_busy_after_start", busy, 1);
    send_byte(8'hA0, ack);
    chk("wr_addr_ack", ack, 0);
    chk("wr_rw", rw, 0);
    rx0 = rx_pulses;
    send_byte(8'hA5, ack);
    chk("wr_data_ack", ack, 0);
    chk("wr_rx_data", rx_data, 8'hA5);
    chk("wr_rx_pulses", rx_pulses - rx0, 1);
    bus_stop();
    tick(4);
    chk("wr_idle", busy, 0);

    // Wrong address 0x51
    rx0 = rx_pulses;
    bus_start();
    send_byte(8'hA2, ack);
    chk("nomatch_nack", ack, 1);
    chk("nomatch_wait_stop", busy, 1);
    send_byte(8'h5A, ack);
    chk("nomatch_ignore_ack", ack, 1);
    chk("nomatch_no_rx", rx_pulses - rx0, 0);
    bus_stop();
    tick(4);
    chk("nomatch_idle", busy, 0);

    // Read 0x50: 0x3C with ACK, 0xC3 with NACK
    tx_valid = 1'b1; tx_data = 8'h3C;
    tx0 = tx_pulses;
    bus_start();
    send_byte(8'hA1, ack);
    chk("rd_addr_ack", ack, 0);
    chk("rd_rw", rw, 1);
    recv_bits(d);
    chk("rd_byte0", d, 8'h3C);
    tx_data = 8'hC3;
    clock_bit(1'b0, x);
    recv_bits(d);
    chk("rd_byte1", d, 8'hC3);
    clock_bit(1'b1, x);
    tick(4);
    chk("rd_wait_stop", busy, 1);
    chk("rd_tx_pulses", tx_pulses - tx0, 2);
    bus_stop();
    tick(4);
    chk("rd_idle", busy, 0);

    // Read with nothing valid returns 0xFF
    tx_valid = 1'b0;
    tx0 = tx_pulses;
    bus_start();
    send_byte(8'hA1, ack);
    chk("rdff_addr_ack", ack, 0);
    recv_bits(d);
    chk("rdff_byte", d, 8'hFF);
    clock_bit(1'b1, x);
    chk("rdff_no_tx_ready", tx_pulses - tx0, 0);
    bus_stop();
    tick(4);

    // Write one byte, repeated START, then read
    bus_start();
    send_byte(8'hA0, ack);
    chk("rs_wr_addr_ack", ack, 0);
    chk("rs_rw0", rw, 0);
    send_byte(8'h11, ack);
    chk("rs_data_ack", ack, 0);
    chk("rs_rx_data", rx_data, 8'h11);
    bus_start();
    send_byte(8'hA1, ack);
    chk("rs_rd_addr_ack", ack, 0);
    chk("rs_rw1", rw, 1);
    recv_bits(d);
    chk("rs_rd_byte", d, 8'hFF);
    clock_bit(1'b1, x);
    bus_stop();
    tick(4);

    // Reset during bit 4 of a received byte
    bus_start();
    send_byte(8'hA0, ack);
    chk("rst_addr_ack", ack, 0);
    rx0 = rx_pulses;
    clock_bit(1'b1, x);
    clock_bit(1'b0, x);
    clock_bit(1'b1, x);
    m_sda = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("rst_sda", sda_o, 1);
    chk("rst_busy", busy, 0);
    tick(1);
    scl = 1'b1; tick(8);
    scl = 1'b0; tick(4);
    for (int i = 0; i < 4; i++) clock_bit(1'b0, x);
    clock_bit(1'b1, ack);
    chk("rst_no_ack", ack, 1);
    chk("rst_no_rx", rx_pulses - rx0, 0);
    chk("rst_still_idle", busy, 0);
    bus_stop();
    tick(4);
    bus_start();
    send_byte(8'hA0, ack);
    chk("rst_new_addr_ack", ack, 0);
    bus_stop();
    tick(4);
    chk("final_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
